// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one 4x4 multiplier among NUM_REQ valid/ready requesters.
// Grant in IDLE, product registered in MUL, response held in RESP until rsp_ready_i (2-cycle latency, no grants while pending).

module mul_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0, a} * {4'b0, b};
endmodule

module mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [4*NUM_REQ-1:0]   req_a_i,
  input  logic [4*NUM_REQ-1:0]   req_b_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [7:0]             rsp_prod_o,
  output logic                   busy_o,
  output logic [15:0]            op_cnt_o
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } opnd_t;

  state_t             state_q, state_d;
  opnd_t              ops [NUM_REQ];
  opnd_t              opnd_q;
  logic [NUM_REQ-1:0] vld_m;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    id_q;
  logic [7:0]         prod;
  logic [7:0]         prod_q;
  logic [15:0]        op_cnt_q;
  logic               grant;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_ops
    assign ops[k] = {req_a_i[4*k +: 4], req_b_i[4*k +: 4]};
  end

  // Valids are masked while in reset so no ready can escape combinationally.
  assign vld_m = req_valid_i & {NUM_REQ{rst_ni}};

  always_comb begin
    logic [ID_W-1:0] cand;
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
      if (!win_vld && vld_m[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign grant = (state_q == IDLE) && win_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[win_id] = 1'b1;
    rsp_valid_o = (state_q == RESP);
    busy_o      = (state_q != IDLE);
  end

  mul_4 u_mul (
    .a (opnd_q.a),
    .b (opnd_q.b),
    .p (prod)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opnd_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      prod_q       <= '0;
      op_cnt_q     <= '0;
    end else begin
      if (grant) begin
        opnd_q       <= ops[win_id];
        id_q         <= win_id;
        last_grant_q <= win_id;
      end
      if (state_q == MUL) prod_q <= prod;
      if (state_q == RESP && rsp_ready_i) op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign rsp_id_o   = id_q;
  assign rsp_prod_o = prod_q;
  assign op_cnt_o   = op_cnt_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed stimulus for mul_share_arb with a queue scoreboard checked by an independent response monitor.

module tb_mul_share_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [15:0] req_a_i;
  logic [15:0] req_b_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_id_o;
  logic [7:0]  rsp_prod_o;
  logic        busy_o;
  logic [15:0] op_cnt_o;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  mul_share_arb #(.NUM_REQ(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_prod_o  (rsp_prod_o),
    .busy_o      (busy_o),
    .op_cnt_o    (op_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_op(input int k, input logic [3:0] a, input logic [3:0] b);
    req_a_i[4*k +: 4] = a;
    req_b_i[4*k +: 4] = b;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) for any ready bit and compares it with the expected one-hot.
  task automatic wait_ready(input logic [3:0] exp, input string nm, output int gc);
    int n;
    n = 0;
    @(negedge clk_i);
    while (req_ready_o == 4'b0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check(nm, 32'(req_ready_o), 32'(exp));
    gc = cyc;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check(nm, 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Response monitor: every accepted response is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id_o), 32'(e.id));
          check("rsp_prod", 32'(rsp_prod_o), 32'(e.prod));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int         gc, prev_gc;
    int         order [5]   = '{0, 1, 2, 3, 0};
    logic [3:0] a_tab [4]   = '{4'd15, 4'd0, 4'd6, 4'd7};
    logic [3:0] b_tab [4]   = '{4'd15, 4'd9, 4'd7, 4'd12};
    logic [7:0] p_tab [4]   = '{8'd225, 8'd0, 8'd42, 8'd84};

    // Reset with all valids high: ready must stay masked.
    rst_ni      = 1'b0;
    req_valid_i = 4'b1111;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cnt", 32'(op_cnt_o), 32'd0);
    check("rst_prod", 32'(rsp_prod_o), 32'd0);
    req_valid_i = 4'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    // Single request from requester 2: 13*11 = 143.
    sb.push_back('{id: 2'd2, prod: 8'd143});
    set_op(2, 4'd13, 4'd11);
    req_valid_i[2] = 1'b1;
    @(negedge clk_i);
    check("t1_ready", 32'(req_ready_o), 32'b0100);
    tick();
    req_valid_i = 4'b0;
    @(negedge clk_i);
    check("t1_mul_valid", 32'(rsp_valid_o), 32'd0);
    check("t1_mul_busy", 32'(busy_o), 32'd1);
    tick();
    @(negedge clk_i);
    check("t1_resp_valid", 32'(rsp_valid_o), 32'd1);
    check("t1_resp_prod", 32'(rsp_prod_o), 32'd143);
    tick();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("t1_cnt", 32'(op_cnt_o), 32'd1);
    check("t1_idle_valid", 32'(rsp_valid_o), 32'd0);

    // Backpressure on requester 3 (12*5 = 60) while all requesters become valid.
    sb.push_back('{id: 2'd3, prod: 8'd60});
    set_op(3, 4'd12, 4'd5);
    req_valid_i[3] = 1'b1;
    wait_ready(4'b1000, "bp_grant", gc);
    tick();
    req_valid_i = 4'b0;
    tick();
    for (int k = 0; k < 4; k++) set_op(k, a_tab[k], b_tab[k]);
    req_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_id", 32'(rsp_id_o), 32'd3);
      check("bp_prod", 32'(rsp_prod_o), 32'd60);
      check("bp_ready", 32'(req_ready_o), 32'd0);
      check("bp_cnt", 32'(op_cnt_o), 32'd1);
      tick();
    end
    rsp_ready_i = 1'b1;

    // Continuous load: grants 0,1,2,3,0 spaced 3 cycles apart.
    prev_gc = 0;
    for (int g = 0; g < 5; g++) begin
      sb.push_back('{id: 2'(order[g]), prod: p_tab[order[g]]});
      wait_ready(4'(1 << order[g]), "t2_grant", gc);
      if (g == 0) check("t2_cnt_start", 32'(op_cnt_o), 32'd2);
      else        check("t2_period", 32'(gc - prev_gc), 32'd3);
      prev_gc = gc;
      tick();
    end
    req_valid_i = 4'b0;

    // Priority after last_grant=0: requester 3 first, then wrap to 0.
    set_op(0, 4'd3, 4'd5);
    set_op(3, 4'd10, 4'd10);
    req_valid_i = 4'b1001;
    sb.push_back('{id: 2'd3, prod: 8'd100});
    sb.push_back('{id: 2'd0, prod: 8'd15});
    wait_ready(4'b1000, "t4_first", gc);
    tick();
    req_valid_i[3] = 1'b0;
    wait_ready(4'b0001, "t4_wrap", gc);
    tick();
    req_valid_i = 4'b0;
    drain("t4_drain");
    check("t4_cnt", 32'(op_cnt_o), 32'd9);

    // Reset during MUL aborts the operation and restores reset priority.
    set_op(1, 4'd2, 4'd3);
    req_valid_i[1] = 1'b1;
    wait_ready(4'b0010, "t5_grant", gc);
    tick();
    rst_ni = 1'b0;
    set_op(0, 4'd4, 4'd4);
    set_op(1, 4'd5, 4'd5);
    req_valid_i = 4'b1111;
    #1;
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_valid", 32'(rsp_valid_o), 32'd0);
    check("t5_id", 32'(rsp_id_o), 32'd0);
    check("t5_prod", 32'(rsp_prod_o), 32'd0);
    check("t5_cnt", 32'(op_cnt_o), 32'd0);
    check("t5_ready", 32'(req_ready_o), 32'd0);
    tick();
    req_valid_i = 4'b0011;
    rst_ni = 1'b1;
    sb.push_back('{id: 2'd0, prod: 8'd16});
    sb.push_back('{id: 2'd1, prod: 8'd25});
    wait_ready(4'b0001, "t5_prio0", gc);
    tick();
    req_valid_i[0] = 1'b0;
    wait_ready(4'b0010, "t5_then1", gc);
    tick();
    req_valid_i = 4'b0;
    drain("t5_drain");
    check("t5_cnt_after", 32'(op_cnt_o), 32'd2);

    // Counter wrap: preload 0xFFFF, one completed response brings it to 0.
    dut.op_cnt_q <= 16'hFFFF;
    @(negedge clk_i);
    check("t6_preload", 32'(op_cnt_o), 32'hFFFF);
    tick();
    set_op(2, 4'd1, 4'd1);
    req_valid_i[2] = 1'b1;
    sb.push_back('{id: 2'd2, prod: 8'd1});
    wait_ready(4'b0100, "t6_grant", gc);
    tick();
    req_valid_i = 4'b0;
    drain("t6_drain");
    check("t6_wrap", 32'(op_cnt_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
